// File: rtl/w80386_prefetch_queue_if.sv
// Handshake bundle of the w80386 prefetch queue: code-read bus towards the
// bus_controller, flush from the execution unit and byte stream to the decoder.
interface w80386_prefetch_queue_if;
  logic        bus_read_vaild;
  logic        bus_read_ready;
  logic [31:0] bus_read_address;
  logic [31:0] bus_read_data;
  logic        flush;
  logic [31:0] flush_address;
  logic        code_valid;
  logic        code_ready;
  logic [7:0]  code_byte;
  logic [31:0] code_eip;

  modport master (
    output bus_read_vaild, bus_read_address, code_valid, code_byte, code_eip,
    input  bus_read_ready, bus_read_data, flush, flush_address, code_ready
  );

  modport slave (
    input  bus_read_vaild, bus_read_address, code_valid, code_byte, code_eip,
    output bus_read_ready, bus_read_data, flush, flush_address, code_ready
  );
endinterface

// File: rtl/w80386_prefetch_queue.sv
// w80386 code prefetch queue: aligned dword code reads into a byte queue, one byte per cycle out.
// Optional macro PREFETCH_PERF_COUNTERS_EN adds fetch/discard/empty-stall counters.
module w80386_prefetch_queue #(
  parameter int unsigned QUEUE_BYTES   = 16,
  parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
  input  logic                     clock,
  input  logic                     reset,
  w80386_prefetch_queue_if.master  io
`ifdef PREFETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              discard_count,
  output logic [31:0]              empty_stall_count
`endif
);

  localparam int unsigned PTR_W = $clog2(QUEUE_BYTES);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             vaild_r;
  logic [31:0]      address_r;
  logic [31:0]      fetch_ptr_r;
  logic [31:0]      code_eip_r;
  logic [7:0]       mem_r [QUEUE_BYTES];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] free_s;
  logic [2:0]       enq_len_s;
  logic             done_s;
  logic             enq_s;
  logic             drop_s;
  logic             pop_s;

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] sel);
    case (sel)
      2'd0:    pick_byte = word[7:0];
      2'd1:    pick_byte = word[15:8];
      2'd2:    pick_byte = word[23:16];
      default: pick_byte = word[31:24];
    endcase
  endfunction

  assign done_s    = (state_r != IDLE) && io.bus_read_ready;
  assign enq_s     = (state_r == REQUEST) && io.bus_read_ready && !io.flush;
  assign drop_s    = done_s && !enq_s;
  assign pop_s     = io.code_valid && io.code_ready && !io.flush;
  // A fetch at an unaligned pointer only keeps the bytes from that offset upward.
  assign enq_len_s = 3'd4 - {1'b0, fetch_ptr_r[1:0]};
  assign free_s    = CNT_W'(QUEUE_BYTES) - count_r;

  assign io.bus_read_vaild   = vaild_r;
  assign io.bus_read_address = address_r;
  assign io.code_valid       = (count_r != {CNT_W{1'b0}});
  assign io.code_byte        = mem_r[head_r];
  assign io.code_eip         = code_eip_r;

  // Next-state logic of the fetch sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!io.flush && (free_s >= CNT_W'(3'd4))) state_s = REQUEST;
        else                                       state_s = IDLE;
      end
      REQUEST: begin
        if (io.bus_read_ready) state_s = IDLE;
        else if (io.flush)     state_s = DISCARD;
        else                   state_s = REQUEST;
      end
      DISCARD: begin
        if (io.bus_read_ready) state_s = IDLE;
        else                   state_s = DISCARD;
      end
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state and the bus request registers; the address is latched only on entry to REQUEST.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      vaild_r   <= 1'b0;
      address_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      vaild_r <= (state_s != IDLE);
      if ((state_r == IDLE) && (state_s == REQUEST)) begin
        address_r <= {fetch_ptr_r[31:2], 2'b00};
      end
    end
  end

  // Fetch pointer: flush always wins, otherwise advance past the dword just enqueued.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_ptr_r <= RESET_ADDRESS;
    end else if (io.flush) begin
      fetch_ptr_r <= io.flush_address;
    end else if (enq_s) begin
      fetch_ptr_r <= address_r + 32'd4;
    end
  end

  // Byte queue storage, pointers, occupancy and head address.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_BYTES; i++) mem_r[i] <= 8'h00;
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      code_eip_r <= 32'h0000_0000;
    end else if (io.flush) begin
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      code_eip_r <= io.flush_address;
    end else begin
      if (enq_s) begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < enq_len_s) begin
            mem_r[tail_r + PTR_W'(i)] <= pick_byte(io.bus_read_data, fetch_ptr_r[1:0] + 2'(i));
          end
        end
        tail_r <= tail_r + PTR_W'(enq_len_s);
      end
      if (pop_s) head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      count_r <= count_r + CNT_W'(enq_s ? enq_len_s : 3'd0) - CNT_W'(pop_s);
      // An empty queue takes its head address from the first byte written into it.
      if (pop_s)                                        code_eip_r <= code_eip_r + 32'd1;
      else if (enq_s && (count_r == {CNT_W{1'b0}}))     code_eip_r <= fetch_ptr_r;
    end
  end

`ifdef PREFETCH_PERF_COUNTERS_EN
  // Performance counters; flush does not clear them.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count       <= 32'd0;
      discard_count     <= 32'd0;
      empty_stall_count <= 32'd0;
    end else begin
      if (enq_s)  fetch_count   <= fetch_count + 32'd1;
      if (drop_s) discard_count <= discard_count + 32'd1;
      if (io.code_ready && !io.code_valid) empty_stall_count <= empty_stall_count + 32'd1;
    end
  end
`endif

endmodule
